sync_filt_multi: RTL and testbench

- Parametrised multi-channel input synchroniser. It is the next generation of the two-flop reset-to-zero synchroniser.
- Per channel:
  - a configurable-depth flop chain,
  - an optional consecutive-sample debounce filter,
  - registered rise, fall and any-change event pulses.
- Sits at the boundary between asynchronous pins (buttons, sensor IRQ, strap, status lines) and the core clock domain. Feeds interrupt and status logic.

---
 rtl/sync_filt_multi.sv | 129 ++++++++++++
 tb/tb_sync_filt_multi.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_filt_multi.sv
// Multi-channel input synchroniser with a per-channel debounce filter and rise/fall/change pulses.
// Optional sticky event flags are built only when SYNC_FILT_STICKY_EN is defined.
module sync_filt_multi #(
  parameter int              WIDTH    = 4,
  parameter int              STAGES   = 2,
  parameter int              FILT_CNT = 0,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
  input  logic             ck,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             chg,
  input  logic [WIDTH-1:0] clr,
  output logic [WIDTH-1:0] sticky
);

  localparam int SYNC_N = (STAGES < 2) ? 2 : STAGES;
  localparam int CNT_W  = (FILT_CNT < 1) ? 1 : $clog2(FILT_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILT_CNT);

  if (STAGES < 2) begin : g_stages_err
    $error("sync_filt_multi: STAGES=%0d is below the minimum of 2", STAGES);
  end

  // Stage 0 is the metastability catcher and must survive optimisation untouched.
  (* keep = "true", dont_touch = "true" *) logic [WIDTH-1:0] sync0_q;
  logic [WIDTH-1:0] sync0_d;
  logic [WIDTH-1:0] sync_q [1:SYNC_N-1];
  logic [WIDTH-1:0] sync_d [1:SYNC_N-1];
  logic [WIDTH-1:0] s;

  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic             chg_q, chg_d;

  always_comb begin
    sync0_d   = d;
    sync_d[1] = sync0_q;
    for (int k = 2; k < SYNC_N; k++) begin
      sync_d[k] = sync_q[k-1];
    end
  end

  assign s = sync_q[SYNC_N-1];

  // Filter: q follows s only after s has disagreed for FILT_CNT+1 consecutive edges.
  always_comb begin
    q_d    = q_q;
    rise_d = '0;
    fall_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (s[i] == q_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        q_d[i]    = s[i];
        cnt_d[i]  = '0;
        rise_d[i] = s[i];
        fall_d[i] = ~s[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
    chg_d = |(rise_d | fall_d);
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      sync0_q <= RST_VAL;
      for (int k = 1; k < SYNC_N; k++) begin
        sync_q[k] <= RST_VAL;
      end
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
      q_q    <= RST_VAL;
      rise_q <= '0;
      fall_q <= '0;
      chg_q  <= 1'b0;
    end else begin
      sync0_q <= sync0_d;
      for (int k = 1; k < SYNC_N; k++) begin
        sync_q[k] <= sync_d[k];
      end
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      q_q    <= q_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      chg_q  <= chg_d;
    end
  end

  assign q    = q_q;
  assign rise = rise_q;
  assign fall = fall_q;
  assign chg  = chg_q;

`ifdef SYNC_FILT_STICKY_EN
  logic [WIDTH-1:0] sticky_q, sticky_d;

  // Set beats clear so an event landing on a clear write is never dropped.
  always_comb begin
    sticky_d = (sticky_q & ~clr) | rise_q | fall_q;
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      sticky_q <= '0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign sticky = sticky_q;
`else
  logic unused_clr;
  assign unused_clr = ^clr;
  assign sticky     = '0;
`endif

endmodule

// File: tb/tb_sync_filt_multi.sv
// Directed bench for sync_filt_multi: WIDTH=4, STAGES=2, FILT_CNT=3, RST_VAL=4'b1010.
module tb_sync_filt_multi;

  logic       ck;
  logic       rst;
  logic [3:0] d;
  logic [3:0] q;
  logic [3:0] rise;
  logic [3:0] fall;
  logic       chg;
  logic [3:0] clr;
  logic [3:0] sticky;

  int vecs;
  int errs;

  sync_filt_multi #(
    .WIDTH   (4),
    .STAGES  (2),
    .FILT_CNT(3),
    .RST_VAL (4'b1010)
  ) dut (
    .ck    (ck),
    .rst   (rst),
    .d     (d),
    .q     (q),
    .rise  (rise),
    .fall  (fall),
    .chg   (chg),
    .clr   (clr),
    .sticky(sticky)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge ck);
    #1;
  endtask

  task automatic reset_settle(input logic [3:0] dv);
    d   = dv;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    repeat (8) tick();
  endtask

  task automatic test_reset;
    logic [3:0] exp_q, exp_f;
    logic       exp_c;
    d   = 4'b0000;
    clr = 4'b0000;
    rst = 1'b1;
    tick();
    vecs++;
    if (q !== 4'b1010) begin $display("FAIL reset_q1: got %b want 1010", q); errs++; end
    vecs++;
    if ({rise, fall, chg, sticky} !== 13'b0) begin
      $display("FAIL reset_evt: got rise=%b fall=%b chg=%b sticky=%b want all 0", rise, fall, chg, sticky); errs++;
    end
    tick();
    vecs++;
    if (q !== 4'b1010) begin $display("FAIL reset_q2: got %b want 1010", q); errs++; end
    rst = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      tick();
      exp_q = (e >= 6) ? 4'b0000 : 4'b1010;
      exp_f = (e == 6) ? 4'b1010 : 4'b0000;
      exp_c = (e == 6);
      vecs++;
      if (q !== exp_q || fall !== exp_f || rise !== 4'b0000 || chg !== exp_c) begin
        $display("FAIL reset_exit e%0d: got q=%b fall=%b rise=%b chg=%b want q=%b fall=%b rise=0000 chg=%b",
                 e, q, fall, rise, chg, exp_q, exp_f, exp_c);
        errs++;
      end
    end
  endtask

  task automatic test_latency;
    logic [3:0] exp_q, exp_r;
    logic       exp_c;
    reset_settle(4'b0000);
    d = 4'b0001;
    for (int e = 1; e <= 7; e++) begin
      tick();
      exp_q = (e >= 6) ? 4'b0001 : 4'b0000;
      exp_r = (e == 6) ? 4'b0001 : 4'b0000;
      exp_c = (e == 6);
      vecs++;
      if (q !== exp_q || rise !== exp_r || fall !== 4'b0000 || chg !== exp_c) begin
        $display("FAIL latency e%0d: got q=%b rise=%b fall=%b chg=%b want q=%b rise=%b fall=0000 chg=%b",
                 e, q, rise, fall, chg, exp_q, exp_r, exp_c);
        errs++;
      end
    end
  endtask

  task automatic test_glitch;
    logic exp_q1, exp_r1, exp_f1;
    // Three-cycle pulse on channel 1 must be swallowed.
    d = 4'b0011;
    for (int e = 1; e <= 12; e++) begin
      tick();
      if (e == 3) d = 4'b0001;
      vecs++;
      if (q[1] !== 1'b0 || rise[1] !== 1'b0 || chg !== 1'b0) begin
        $display("FAIL glitch3 e%0d: got q1=%b rise1=%b chg=%b want 0 0 0", e, q[1], rise[1], chg);
        errs++;
      end
    end
    // Four-cycle pulse passes: high after edge 6, low after edge 10.
    d = 4'b0011;
    for (int e = 1; e <= 12; e++) begin
      tick();
      if (e == 4) d = 4'b0001;
      exp_q1 = (e >= 6 && e <= 9);
      exp_r1 = (e == 6);
      exp_f1 = (e == 10);
      vecs++;
      if (q[1] !== exp_q1 || rise[1] !== exp_r1 || fall[1] !== exp_f1 || chg !== (exp_r1 | exp_f1) || q[0] !== 1'b1) begin
        $display("FAIL glitch4 e%0d: got q=%b rise1=%b fall1=%b chg=%b want q1=%b rise1=%b fall1=%b q0=1",
                 e, q, rise[1], fall[1], chg, exp_q1, exp_r1, exp_f1);
        errs++;
      end
    end
  endtask

  task automatic test_simultaneous;
    int n_chg;
    reset_settle(4'b0000);
    d     = 4'b0101;
    n_chg = 0;
    for (int e = 1; e <= 10; e++) begin
      tick();
      if (chg === 1'b1) n_chg++;
      if (e == 6) begin
        vecs++;
        if (rise !== 4'b0101 || fall !== 4'b0000 || q !== 4'b0101 || chg !== 1'b1) begin
          $display("FAIL simul_edge6: got rise=%b fall=%b q=%b chg=%b want 0101 0000 0101 1", rise, fall, q, chg);
          errs++;
        end
      end
      if (e == 7) begin
        vecs++;
        if (rise !== 4'b0000 || q !== 4'b0101) begin
          $display("FAIL simul_edge7: got rise=%b q=%b want 0000 0101", rise, q);
          errs++;
        end
      end
    end
    vecs++;
    if (n_chg !== 1) begin $display("FAIL simul_chg_count: got %0d want 1", n_chg); errs++; end
  endtask

  task automatic test_mid_reset;
    logic [3:0] exp_q, exp_r, exp_f;
    reset_settle(4'b0000);
    d = 4'b0100;
    for (int e = 1; e <= 4; e++) tick();
    vecs++;
    if (q !== 4'b0000 || dut.cnt_q[2] !== 2'd2) begin
      $display("FAIL midrst_pre: got q=%b cnt2=%0d want q=0000 cnt2=2", q, dut.cnt_q[2]);
      errs++;
    end
    rst = 1'b1;
    tick();
    vecs++;
    if (q !== 4'b1010 || dut.cnt_q[2] !== 2'd0 || {rise, fall, chg} !== 9'b0) begin
      $display("FAIL midrst_during: got q=%b cnt2=%0d rise=%b fall=%b chg=%b want q=1010 cnt2=0 no events",
               q, dut.cnt_q[2], rise, fall, chg);
      errs++;
    end
    rst = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      tick();
      exp_q = (e >= 6) ? 4'b0100 : 4'b1010;
      exp_r = (e == 6) ? 4'b0100 : 4'b0000;
      exp_f = (e == 6) ? 4'b1010 : 4'b0000;
      vecs++;
      if (q !== exp_q || rise !== exp_r || fall !== exp_f || chg !== (e == 6)) begin
        $display("FAIL midrst_after e%0d: got q=%b rise=%b fall=%b chg=%b want q=%b rise=%b fall=%b",
                 e, q, rise, fall, chg, exp_q, exp_r, exp_f);
        errs++;
      end
    end
  endtask

  task automatic test_sticky;
`ifdef SYNC_FILT_STICKY_EN
    reset_settle(4'b0000);
    clr = 4'b1111;
    tick();
    clr = 4'b0000;
    vecs++;
    if (sticky !== 4'b0000) begin $display("FAIL sticky_clrall: got %b want 0000", sticky); errs++; end
    d = 4'b0001;
    for (int e = 1; e <= 6; e++) tick();
    vecs++;
    if (rise !== 4'b0001 || sticky !== 4'b0000) begin
      $display("FAIL sticky_pre: got rise=%b sticky=%b want 0001 0000", rise, sticky); errs++;
    end
    tick();
    vecs++;
    if (sticky !== 4'b0001) begin $display("FAIL sticky_set: got %b want 0001", sticky); errs++; end
    d = 4'b0000;
    for (int e = 1; e <= 6; e++) tick();
    vecs++;
    if (fall !== 4'b0001) begin $display("FAIL sticky_fall: got fall=%b want 0001", fall); errs++; end
    clr = 4'b0001;
    tick();
    vecs++;
    if (sticky !== 4'b0001) begin $display("FAIL sticky_setwins: got %b want 0001", sticky); errs++; end
    tick();
    clr = 4'b0000;
    vecs++;
    if (sticky !== 4'b0000) begin $display("FAIL sticky_clr: got %b want 0000", sticky); errs++; end
`else
    reset_settle(4'b0000);
    d   = 4'b1111;
    clr = 4'b1111;
    for (int e = 1; e <= 8; e++) begin
      tick();
      if (e == 4) clr = 4'b0000;
      vecs++;
      if (sticky !== 4'b0000) begin $display("FAIL sticky_off e%0d: got %b want 0000", e, sticky); errs++; end
    end
    vecs++;
    if (q !== 4'b1111) begin $display("FAIL sticky_off_q: got %b want 1111", q); errs++; end
`endif
  endtask

  initial begin
    vecs = 0;
    errs = 0;
    rst  = 1'b1;
    d    = 4'b0000;
    clr  = 4'b0000;
    test_reset();
    test_latency();
    test_glitch();
    test_simultaneous();
    test_mid_reset();
    test_sticky();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
